// File: rtl/alu_arb.sv
// Two-port round-robin arbiter feeding a shared integer ALU through a one-deep
// issue register; the ALU result is captured into a shared response register.
module alu_arb #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_ctr,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_ctr,
  input  logic                  flush0,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctr,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp0_zero,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp1_zero
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [3:0]            ctr;
  } op_t;

  op_t [1:0]             req;
  logic [1:0]            eff, gnt;
  logic                  prio;
  logic                  iss_v, iss_port;
  op_t                   iss;
  logic                  rsp_v, rsp_port;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_zero;

  assign req[0] = '{a: req0_a, b: req0_b, ctr: req0_ctr};
  assign req[1] = '{a: req1_a, b: req1_b, ctr: req1_ctr};
  assign eff    = {req1_valid, req0_valid & ~flush0};

  // Reset suppresses grants so a requester never sees an acceptance that is lost.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (eff == 2'b11) gnt[prio] = 1'b1;
      else              gnt = eff;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      iss_v    <= 1'b0;
      iss_port <= 1'b0;
      iss      <= '0;
      rsp_v    <= 1'b0;
      rsp_port <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else begin
      iss_v <= |gnt;
      if (|gnt) begin
        prio     <= ~gnt[1];
        iss_port <= gnt[1];
        iss      <= req[gnt[1]];
      end
      // A flush kills only a port-0 op still in the issue stage.
      rsp_v    <= iss_v & ~(flush0 & ~iss_port);
      rsp_port <= iss_port;
      rsp_data <= alu_out;
      rsp_zero <= alu_zero;
    end
  end

  assign alu_a   = iss.a;
  assign alu_b   = iss.b;
  assign alu_ctr = iss_v ? iss.ctr : 4'b0000;

  assign rsp0_valid = rsp_v & ~rsp_port;
  assign rsp1_valid = rsp_v &  rsp_port;
  assign rsp0_data  = rsp_data;
  assign rsp1_data  = rsp_data;
  assign rsp0_zero  = rsp_zero;
  assign rsp1_zero  = rsp_zero;

endmodule
